// File: rtl/pacman_input_ctrl.sv
// Player-control front end: per-button 2-flop synchronizer and counter debouncer,
// last-pressed-wins direction arbiter with registered one-hot outputs, and a
// single-cycle ack/start pulse on each debounced press of the center button.
module pacman_input_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 19
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btnL,
   input  logic       btnR,
   input  logic       btnU,
   input  logic       btnD,
   input  logic       btnC,
   output logic       Left,
   output logic       Right,
   output logic       Up,
   output logic       Down,
   output logic       ack,
   output logic [2:0] dir_code
);

   // Button indices; the L, U, R, D order doubles as arbitration priority.
   localparam int unsigned IdxL = 0;
   localparam int unsigned IdxU = 1;
   localparam int unsigned IdxR = 2;
   localparam int unsigned IdxD = 3;
   localparam int unsigned IdxC = 4;
   localparam int unsigned NumBtn = 5;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Encoding matches dir_code so the state register drives it directly.
   typedef enum logic [2:0] {
      StNone = 3'd0,
      StL    = 3'd1,
      StU    = 3'd2,
      StR    = 3'd3,
      StD    = 3'd4
   } dir_state_e;

   logic [NumBtn-1:0] raw;
   logic [NumBtn-1:0] sync1_q, sync2_q;
   logic [NumBtn-1:0] deb_q, deb_d, deb_prev_q;
   logic [NumBtn-1:0] rise, fall;
   logic [CNT_W-1:0]  cnt_q [NumBtn];
   logic [CNT_W-1:0]  cnt_d [NumBtn];
   dir_state_e        state_q, state_d;

   assign raw = {btnC, btnD, btnR, btnU, btnL};

   // Two-flop synchronizer per button.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   // Debounce next state: level follows the synchronized input only after
   // DEBOUNCE_CYCLES consecutive disagreeing samples; any agreement restarts.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < NumBtn; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntLast) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Debounce counters, levels and the previous level for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb_q      <= '0;
         deb_prev_q <= '0;
         for (int i = 0; i < NumBtn; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         for (int i = 0; i < NumBtn; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign rise = deb_q & ~deb_prev_q;
   assign fall = ~deb_q & deb_prev_q;

   // Arbiter state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StNone;
      end else begin
         state_q <= state_d;
      end
   end

   // Arbiter next state: newest press wins; releasing the active direction
   // drops to none without falling back to other held buttons.
   always_comb begin
      state_d = state_q;
      if (rise[IdxL]) begin
         state_d = StL;
      end else if (rise[IdxU]) begin
         state_d = StU;
      end else if (rise[IdxR]) begin
         state_d = StR;
      end else if (rise[IdxD]) begin
         state_d = StD;
      end else begin
         case (state_q)
            StL:     if (fall[IdxL]) state_d = StNone;
            StU:     if (fall[IdxU]) state_d = StNone;
            StR:     if (fall[IdxR]) state_d = StNone;
            StD:     if (fall[IdxD]) state_d = StNone;
            default: state_d = state_q;
         endcase
      end
   end

   // Registered one-hot decode and the center-press pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Left  <= 1'b0;
         Right <= 1'b0;
         Up    <= 1'b0;
         Down  <= 1'b0;
         ack   <= 1'b0;
      end else begin
         Left  <= (state_d == StL);
         Right <= (state_d == StR);
         Up    <= (state_d == StU);
         Down  <= (state_d == StD);
         ack   <= rise[IdxC];
      end
   end

   assign dir_code = state_q;

endmodule
